// File: rtl/candidate_bank_reader_if.sv
// ============================================================================
// Module      : candidate_bank_reader_if
// Description : Bank access and candidate stream signals of the bank reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface candidate_bank_reader_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] mem_index;
  logic                  mem_wr_en;
  logic [WORD_WIDTH-1:0] mem_wr_data;
  logic [WORD_WIDTH-1:0] mem_rd_data;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output mem_index, mem_wr_en, mem_wr_data,
    input  mem_rd_data,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_index, mem_wr_en, mem_wr_data,
    output mem_rd_data,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/candidate_bank_reader.sv
// ============================================================================
// Module      : candidate_bank_reader
// Description : Streams a run of big-endian 16-bit candidate entries from the
//               byte bank to a valid/ready consumer. Optional CANDREAD_CLEAR_EN
//               zeroes each entry after it has been consumed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module candidate_bank_reader #(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_DEPTH  = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  candidate_bank_reader_if.master bus
);

  localparam int                 c_addr_w  = $clog2(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_max_cnt = CNT_WIDTH'(MEM_DEPTH / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PRESENT = 3'd2,
    S_DONE    = 3'd3
`ifdef CANDREAD_CLEAR_EN
    , S_CLEAR = 3'd4
`endif
  } state_t;

  state_t                r_state;
  logic [c_addr_w-1:0]   r_addr;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [WORD_WIDTH-1:0] r_mem_index;
  logic [WORD_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;

  logic [c_addr_w-1:0]   w_base_even;
  logic [c_addr_w-1:0]   w_next_addr;
  logic [CNT_WIDTH-1:0]  w_eff_count;
  logic                  w_final;
  logic                  w_unused;

  // Address arithmetic is done at bank width so it wraps modulo MEM_DEPTH.
  assign w_base_even = {base_addr[c_addr_w-1:1], 1'b0};
  assign w_next_addr = r_addr + c_addr_w'(2);
  assign w_eff_count = (count > c_max_cnt) ? c_max_cnt : count;
  assign w_final     = (r_remaining == CNT_WIDTH'(1));
  assign w_unused    = &{1'b0, base_addr[WORD_WIDTH-1:c_addr_w], base_addr[0]};

`ifdef CANDREAD_CLEAR_EN
  logic r_mem_wr_en;
  assign bus.mem_wr_en = r_mem_wr_en;
`else
  assign bus.mem_wr_en = 1'b0;
`endif

  assign bus.mem_wr_data = '0;
  assign bus.mem_index   = r_mem_index;
  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_last    = r_out_last;
  assign busy            = r_busy;
  assign done            = r_done;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_mem_index <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef CANDREAD_CLEAR_EN
      r_mem_wr_en <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_addr      <= w_base_even;
              r_remaining <= w_eff_count;
              r_mem_index <= WORD_WIDTH'(w_base_even);
            end
          end
        end

        S_FETCH: begin
          r_out_data  <= bus.mem_rd_data;
          r_out_valid <= 1'b1;
          r_out_last  <= w_final;
          r_state     <= S_PRESENT;
        end

        S_PRESENT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef CANDREAD_CLEAR_EN
            r_state     <= S_CLEAR;
            r_mem_wr_en <= 1'b1;
`else
            r_addr      <= w_next_addr;
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            if (w_final) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_mem_index <= '0;
            end else begin
              r_state     <= S_FETCH;
              r_mem_index <= WORD_WIDTH'(w_next_addr);
            end
`endif
          end
        end

`ifdef CANDREAD_CLEAR_EN
        // mem_index still holds the consumed entry's address during this cycle.
        S_CLEAR: begin
          r_mem_wr_en <= 1'b0;
          r_addr      <= w_next_addr;
          r_remaining <= r_remaining - CNT_WIDTH'(1);
          if (w_final) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_mem_index <= '0;
          end else begin
            r_state     <= S_FETCH;
            r_mem_index <= WORD_WIDTH'(w_next_addr);
          end
        end
`endif

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_candidate_bank_reader.sv
// ============================================================================
// Module      : tb_candidate_bank_reader
// Description : Self-checking bench for candidate_bank_reader (vector table,
//               directed corner sequences and randomized runs vs. a model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_candidate_bank_reader;

`ifdef CANDREAD_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] base_addr;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic [7:0]  bank [32];
  logic [4:0]  w_idx;

  int n_checks = 0;
  int n_fail   = 0;

  candidate_bank_reader_if #(.WORD_WIDTH(16)) bus ();

  candidate_bank_reader #(
    .WORD_WIDTH(16),
    .MEM_DEPTH (32),
    .CNT_WIDTH (5)
  ) u_dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign w_idx = bus.mem_index[4:0];
  assign bus.mem_rd_data = {bank[w_idx], bank[w_idx + 5'd1]};

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [63:0] all_outs();
    return {11'd0, busy, done, bus.mem_index, bus.mem_wr_en, bus.mem_wr_data,
            bus.out_data, bus.out_valid, bus.out_last};
  endfunction

  task automatic load_fixed();
    for (int i = 0; i < 32; i++) bank[i] = 8'(i * 7 + 3);
    bank[0] = 8'h12; bank[1] = 8'h34; bank[2] = 8'h56;
    bank[3] = 8'h78; bank[4] = 8'h9A; bank[5] = 8'hBC;
    bank[30] = 8'hAA; bank[31] = 8'hBB;
  endtask

  task automatic start_pulse(input logic [15:0] b, input logic [4:0] c);
    @(negedge clk);
    base_addr = b; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!bus.out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.out_valid, 1'b1);
  endtask

  // One run: stimulus with random backpressure, then the whole observed
  // stream is compared with entries computed straight from the bank bytes.
  task automatic do_run(input logic [15:0] b, input logic [4:0] c, input int pct,
                        output int n_out, output logic [15:0] first);
    logic [7:0]  snap [32];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    bit          last_q [$];
    int          eff, cyc, first_valid, last_hs, done_at, a, wr_cnt, bad, exp_done;
    bit          stall, rdy;
    logic [15:0] held;

    for (int i = 0; i < 32; i++) snap[i] = bank[i];
    eff = (int'(c) > 16) ? 16 : int'(c);
    for (int i = 0; i < eff; i++) begin
      a = ((int'(b) & 32'hFFFE) + 2 * i) % 32;
      exp_q.push_back({snap[a], snap[(a + 1) % 32]});
    end
    first_valid = -1; last_hs = -1; done_at = -1; wr_cnt = 0;
    stall = 1'b0; held = '0;

    @(negedge clk);
    base_addr = b; count = c; start = 1'b1; bus.out_ready = 1'b0;
    cyc = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_at < 0 && cyc < 300) begin
      if (stall) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.out_data, held);
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.mem_wr_en) begin
        wr_cnt++;
        check("wr_data_zero", bus.mem_wr_data, 16'h0);
        bank[w_idx]        = 8'h00;
        bank[w_idx + 5'd1] = 8'h00;
      end
      if (done) done_at = cyc;
      rdy = ($urandom_range(99) < pct);
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        got_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        last_hs = cyc;
        stall = 1'b0;
      end else begin
        stall = bus.out_valid;
        held  = bus.out_data;
      end
      if (done_at < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.out_ready = 1'b0;
    if (done_at < 0) check("done_timeout", 1'b0, 1'b1);

    check("n_entries", got_q.size(), eff);
    for (int i = 0; i < got_q.size() && i < eff; i++) begin
      check("entry_data", got_q[i], exp_q[i]);
      check("entry_last", last_q[i], (i == eff - 1));
    end
    exp_done = (eff == 0) ? 1 : last_hs + 1 + CLR;
    check("done_timing", done_at, exp_done);
    if (eff > 0) check("first_valid_latency", first_valid, 2);
    check("wr_count", wr_cnt, CLR * eff);

    @(negedge clk);
    check("idle_after_done", {done, busy, bus.out_valid, bus.mem_index}, 0);

    if (CLR != 0) begin
      for (int i = 0; i < eff; i++) begin
        a = ((int'(b) & 32'hFFFE) + 2 * i) % 32;
        snap[a] = 8'h00;
        snap[(a + 1) % 32] = 8'h00;
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (bank[i] !== snap[i]) bad++;
    check("bank_contents", bad, 0);

    n_out = got_q.size();
    first = (got_q.size() > 0) ? got_q[0] : 16'h0;
  endtask

  typedef struct {
    logic [15:0] base;
    logic [4:0]  cnt;
    int          pct;
    int          exp_n;
    logic [15:0] exp_first;
  } vec_t;

  vec_t        vecs [6];
  int          n_out;
  logic [15:0] first;
  logic [15:0] got3 [$];
  logic [15:0] idx0;
  int          k;

  initial begin
    vecs[0] = '{16'd0,  5'd3,  100, 3,  16'h1234};
    vecs[1] = '{16'd30, 5'd2,  100, 2,  16'hAABB};
    vecs[2] = '{16'd3,  5'd1,  100, 1,  16'h5678};
    vecs[3] = '{16'd0,  5'd0,  100, 0,  16'h0000};
    vecs[4] = '{16'd0,  5'd20, 100, 16, 16'h1234};
    vecs[5] = '{16'd0,  5'd3,  30,  3,  16'h1234};

    nrst = 1'b0; start = 1'b0; base_addr = '0; count = '0; bus.out_ready = 1'b0;
    load_fixed();
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'h0);
    nrst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      load_fixed();
      do_run(vecs[v].base, vecs[v].cnt, vecs[v].pct, n_out, first);
      check("tbl_count", n_out, vecs[v].exp_n);
      if (vecs[v].exp_n > 0) check("tbl_first", first, vecs[v].exp_first);
    end

    // Backpressure: first entry held five cycles, address must not move.
    load_fixed();
    bus.out_ready = 1'b0;
    start_pulse(16'd0, 5'd3);
    wait_valid("bp_valid");
    idx0 = bus.mem_index;
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", {bus.out_valid, bus.out_data, bus.mem_index}, {1'b1, 16'h1234, idx0});
      @(negedge clk);
    end
    got3.delete();
    bus.out_ready = 1'b1;
    k = 0;
    while (!done && k < 20) begin
      if (bus.out_valid) got3.push_back(bus.out_data);
      @(negedge clk);
      k++;
    end
    bus.out_ready = 1'b0;
    check("bp_done", done, 1'b1);
    check("bp_stream", {got3.size() == 3 ? {got3[0], got3[1], got3[2]} : 48'h0},
          {16'h1234, 16'h5678, 16'h9ABC});
    @(negedge clk);

    // start while busy must be dropped, not queued.
    load_fixed();
    start_pulse(16'd0, 5'd1);
    wait_valid("busy_valid");
    start_pulse(16'd4, 5'd3);
    check("busy_ignore_data", {bus.out_valid, bus.out_data}, {1'b1, 16'h1234});
    bus.out_ready = 1'b1;
    k = 0;
    n_out = 0;
    while (!done && k < 20) begin
      if (bus.out_valid) n_out++;
      @(negedge clk);
      k++;
    end
    bus.out_ready = 1'b0;
    check("busy_ignore_n", n_out, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_not_queued", {busy, bus.out_valid}, 2'b00);
    end

    // Asynchronous reset in PRESENT, then a clean new run.
    load_fixed();
    start_pulse(16'd0, 5'd3);
    wait_valid("rst_valid");
    #2 nrst = 1'b0;
    #1 check("rst_async", all_outs(), 64'h0);
    @(negedge clk);
    nrst = 1'b1;
    check("rst_held", all_outs(), 64'h0);
    load_fixed();
    do_run(16'd0, 5'd3, 100, n_out, first);
    check("rst_rerun_first", first, 16'h1234);

    // Randomized runs against the model.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 32; i++) bank[i] = 8'($urandom);
      do_run(16'($urandom), 5'($urandom_range(0, 31)), int'($urandom_range(25, 100)), n_out, first);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
